dmem_bank: RTL
==============

Name: dmem_bank

Overview:
- Parametrised single-port data memory for the pipeline CPU's MEM stage; generation after the fixed 256x32 word RAM.
- Adds configurable width, depth and base address, byte-lane write strobes, and a valid/ready request channel.
- Adds configurable registered read latency, range and alignment error reporting, and a hardware clear sequence after reset.
- Exactly one request outstanding at a time.

Parameters:
- DATA_W, 32, data word width in bits; a multiple of 8.
- DEPTH, 256, number of words; a power of 2, at least 4.
- ADDR_W, 32, byte-address width.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to DEPTH*DATA_W/8.
- READ_LAT, 1, cycles from read acceptance to response; range 1..4.

Ports:
- clk, input, 1, clock; all state changes on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- req_valid, input, 1, request present.
- req_ready, output, 1, block can accept a request this cycle.
- req_we, input, 1, 1 = write, 0 = read.
- req_be, input, DATA_W/8, byte-lane write strobes; ignored for reads.
- req_addr, input, ADDR_W, byte address.
- req_wdata, input, DATA_W, write data.
- rsp_valid, output, 1, one-cycle response pulse.
- rsp_rdata, output, DATA_W, read data; 0 for writes and errors.
- rsp_err, output, 1, request was out of range or misaligned.
- init_done, output, 1, clear sequence complete.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Outputs: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_done=0.
  - State goes to CLEAR, clear counter goes to 0, any pending response is discarded.
- States:
  - CLEAR: writes 0 to word[cnt] each cycle, cnt increments. After word DEPTH-1 is written, go to IDLE and set init_done=1; init_done stays 1 until the next reset. req_ready=0 throughout, so CLEAR takes DEPTH cycles.
  - IDLE: req_ready=1. Acceptance = req_valid & req_ready at a rising edge; on acceptance go to BUSY and deassert req_ready the next cycle.
  - BUSY: req_ready=0. Internal latency counter counts to L, where L=1 for writes and errors and L=READ_LAT for valid reads. At count L, drive rsp_valid=1 for one cycle together with rsp_rdata and rsp_err, then return to IDLE. req_ready=1 in the cycle after rsp_valid, so back-to-back requests are spaced L+1 cycles apart.
- Address decode:
  - off = req_addr - BASE_ADDR (modulo 2^ADDR_W).
  - Error if off >= DEPTH*DATA_W/8, or if off[log2(DATA_W/8)-1:0] != 0 (misaligned).
  - Word index = off >> log2(DATA_W/8).
- Write: at the acceptance edge, each byte lane i with req_be[i]=1 is replaced from req_wdata; other lanes are unchanged. req_be all-zero is legal: no change, rsp_err=0.
- Read: data is sampled at the acceptance edge and carried through the latency pipeline. A write accepted earlier is always visible, because requests are serialised.
- Error request: memory unchanged, rsp_rdata=0, rsp_err=1, latency 1.
- Inputs are don't-care while req_valid=0. Requests presented while req_ready=0 are not accepted, and the requester must hold them stable.
- rsp_rdata and rsp_err return to 0 in every cycle where rsp_valid=0.
- Reset asserted mid-CLEAR or mid-BUSY: the outstanding request is dropped with no response; CLEAR restarts from word 0.
- Memory is inferred RAM, 1 write port. The CLEAR write and the request write are muxed onto it; they never coincide.

Optional Feature:
- Macro: DMEM_BANK_TRACE_EN.
- Defined: on every accepted write, simulation prints the byte address (hex), word index (dec), req_be (bin), and write data (hex and dec), under a "Write cycle DMEM" banner. On every error request it prints "DMEM error" with the address. Printing is simulation-only and has no effect on synthesis or timing.
- Undefined: no display statements are compiled; functional behaviour is identical.

Test Plan:
- Reset, then release rst_n: req_ready=0 and init_done=0 for exactly 256 cycles, then init_done=1 and req_ready=1. A read of 0x0 returns 0x00000000, rsp_err=0.
- Write 0x0000_0010 with data 0xDEADBEEF and be=4'b1111; then write 0x10 with data 0x000000AA and be=4'b0001; read 0x10 -> rsp_rdata=0xDEADBEAA.
- READ_LAT=3: accept a read at cycle t. rsp_valid is high only in cycle t+3, req_ready is low from t+1 to t+3, and a new request is accepted at t+4.
- Reads of 0x400 (out of range, DEPTH=256) and 0x6 (misaligned) -> rsp_err=1, rsp_rdata=0, latency 1. A write to 0x400 leaves all words unchanged, checked by reading back 0x0 and 0x3FC.
- BASE_ADDR=0x1000_0000: write 0x1000_03FC with 0x12345678, read it back -> 0x12345678. Access to 0x0FFF_FFFC -> rsp_err=1.
- Write 0x20=0x55, then assert rst_n=0 while a read is in BUSY: no rsp_valid appears and CLEAR restarts. After init_done, a read of 0x20 returns 0.

Source files
------------

// File: rtl/dmem_bank.sv
// dmem_bank: single-port data memory with byte strobes, a valid/ready request channel,
// registered read latency and a clear sweep after reset. Define DMEM_BANK_TRACE_EN for write/error tracing.
module dmem_bank #(
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       DEPTH     = 256,
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned       READ_LAT  = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [DATA_W/8-1:0] req_be,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                init_done
);

    localparam int unsigned       BYTES     = DATA_W / 8;
    localparam int unsigned       IDX_W     = $clog2(DEPTH);
    localparam int unsigned       LANE_SH   = $clog2(BYTES);
    localparam logic [ADDR_W:0]   SPAN      = (ADDR_W + 1)'(DEPTH * BYTES);
    localparam logic [ADDR_W-1:0] LANE_MASK = ADDR_W'(BYTES - 1);

    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_BUSY} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  clr_cnt_q;
    logic [2:0]        lat_cnt_q, lat_tgt_q;
    logic              err_q, rd_ok_q, init_done_q;
    logic [DATA_W-1:0] rd_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] off;
    logic              addr_err, accept, rd_en, rsp_now;
    logic [IDX_W-1:0]  req_idx;

    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [BYTES-1:0]  wr_be;
    logic [DATA_W-1:0] wr_data;

    assign off      = req_addr - BASE_ADDR;
    assign addr_err = ({1'b0, off} >= SPAN) || ((off & LANE_MASK) != '0);
    assign req_idx  = IDX_W'(off >> LANE_SH);
    assign accept   = req_valid && req_ready;
    assign rd_en    = accept && !req_we && !addr_err;
    assign rsp_now  = (state_q == S_BUSY) && (lat_cnt_q == lat_tgt_q);

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = rsp_now;
    assign rsp_rdata = (rsp_now && rd_ok_q) ? rd_q : '0;
    assign rsp_err   = rsp_now && err_q;
    assign init_done = init_done_q;

    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_CLEAR: if (clr_cnt_q == IDX_W'(DEPTH - 1)) state_d = S_IDLE;
            S_IDLE:  if (accept) state_d = S_BUSY;
            S_BUSY:  if (rsp_now) state_d = S_IDLE;
            default: state_d = S_CLEAR;
        endcase
    end

    // The clear sweep and request writes share the single write port; they never overlap.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = req_idx;
        wr_be   = req_be;
        wr_data = req_wdata;
        if (state_q == S_CLEAR) begin
            wr_en   = 1'b1;
            wr_idx  = clr_cnt_q;
            wr_be   = '1;
            wr_data = '0;
        end else if (accept && req_we && !addr_err) begin
            wr_en = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_CLEAR;
            clr_cnt_q   <= '0;
            lat_cnt_q   <= '0;
            lat_tgt_q   <= 3'd1;
            err_q       <= 1'b0;
            rd_ok_q     <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_CLEAR) begin
                clr_cnt_q <= clr_cnt_q + 1'b1;
                if (state_d == S_IDLE) init_done_q <= 1'b1;
            end
            if (accept) begin
                lat_cnt_q <= 3'd1;
                err_q     <= addr_err;
                rd_ok_q   <= rd_en;
                lat_tgt_q <= rd_en ? 3'(READ_LAT) : 3'd1;
            end else if (state_q == S_BUSY) begin
                lat_cnt_q <= lat_cnt_q + 1'b1;
            end
        end
    end

    // NOTE: the array has no reset so it maps onto RAM; the clear sweep provides the zero contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < BYTES; i++) begin
                if (wr_be[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
        if (rd_en) rd_q <= mem[req_idx];
    end

`ifdef DMEM_BANK_TRACE_EN
    always @(posedge clk) begin
        if (rst_n && accept && req_we && !addr_err) begin
            $display("Write cycle DMEM");
            $display("  addr=0x%h word=%0d be=%b data=0x%h (%0d)", req_addr, req_idx, req_be, req_wdata, req_wdata);
        end
        if (rst_n && accept && addr_err) $display("DMEM error addr=0x%h", req_addr);
    end
`endif

endmodule
